sccb_arbiter: RTL and testbench

- Shares the single SCCB register-access port of the camera configuration controller between two requesters.
- Requester 0 is the UART command path. Requester 1 is an on-chip agent, e.g. a switch-driven filter/exposure preset loader.
- Grants are round-robin. A transaction is forwarded as a held rreq/wreq until com_done, and the result is returned to the granted requester.
- A timeout guards against a hung bus. Sits between the requesters and the SCCB controller, in the clk25 domain.

---
 rtl/sccb_arb_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/sccb_arbiter.sv | 118 +++++++++++
 tb/tb_sccb_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sccb_arb_pkg.sv
// Shared types and constants for the SCCB register-port arbiter.
package sccb_arb_pkg;

  localparam int NUM_REQ         = 2;
  localparam int TIMEOUT_CYC_DEF = 2000000;  // 80 ms at 25 MHz

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // One-hot requester mask from a requester index.
  function automatic logic [NUM_REQ-1:0] req_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: ties go to the requester not granted last time.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant,
  output logic       valid
);

  logic last_grant;

  assign valid = |req;

  always_comb begin
    grant = req[1];
    if (&req) grant = ~last_grant;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 last_grant <= 1'b1;
    else if (update && valid) last_grant <= grant;
  end

endmodule

// File: rtl/sccb_arbiter.sv
// Shares the SCCB register-access port between the UART path (0) and an
// on-chip agent (1); round-robin grant, held request, timeout abort.
module sccb_arbiter
  import sccb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TO_W        = 21
) (
  input  logic               clk25,
  input  logic               RESET,
  input  logic               init_done,
  input  logic [NUM_REQ-1:0] r_rreq,
  input  logic [NUM_REQ-1:0] r_wreq,
  input  logic [15:0]        r_addr,
  input  logic [15:0]        r_wdata,
  output logic [NUM_REQ-1:0] r_done,
  output logic [NUM_REQ-1:0] r_err,
  output logic [7:0]         r_rdata,
  output logic               m_rreq,
  output logic               m_wreq,
  output logic [7:0]         m_addr,
  output logic [7:0]         m_data_write,
  input  logic [7:0]         m_data_read,
  input  logic               m_com_done,
  output logic               busy
);

  arb_state_t state_q, state_d;

  logic [NUM_REQ-1:0][7:0] addr_v, wdata_v;
  logic [NUM_REQ-1:0]      req;
  logic                    g, any_req, conflict, start, grant_take, to_hit;
  logic                    g_q, rd_q, err_q;
  logic [7:0]              addr_q, wdata_q, rdata_q;
  logic [TO_W-1:0]         to_cnt;

  assign addr_v     = r_addr;
  assign wdata_v    = r_wdata;
  assign req        = r_rreq | r_wreq;
  assign conflict   = r_rreq[g] & r_wreq[g];
  assign start      = (state_q == IDLE) && init_done && any_req;
  // A conflicting request is answered with an error and does not count as a turn.
  assign grant_take = start && !conflict;
  assign to_hit     = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  rr_arbiter2 u_rr (
    .clk    (clk25),
    .rst    (RESET),
    .req    (req),
    .update (grant_take),
    .grant  (g),
    .valid  (any_req)
  );

  always_ff @(posedge clk25 or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = conflict ? RESP : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (m_com_done || to_hit) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or posedge RESET) begin
    if (RESET) begin
      g_q     <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      to_cnt  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          g_q     <= g;
          err_q   <= conflict;
          rdata_q <= '0;
          if (!conflict) begin
            rd_q    <= r_rreq[g];
            addr_q  <= addr_v[g];
            wdata_q <= wdata_v[g];
          end
        end
        ISSUE: to_cnt <= '0;
        WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          // com_done takes priority over a timeout in the same cycle.
          if (m_com_done) begin
            err_q <= 1'b0;
            if (rd_q) rdata_q <= m_data_read;
          end else if (to_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_addr       = addr_q;
  assign m_data_write = wdata_q;
  assign m_rreq       = (state_q == WAIT) &&  rd_q;
  assign m_wreq       = (state_q == WAIT) && !rd_q;
  assign busy         = (state_q != IDLE);
  assign r_done       = (state_q == RESP) ? req_mask(g_q) : '0;
  assign r_err        = err_q ? r_done : '0;
  assign r_rdata      = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Self-checking bench for sccb_arbiter: transaction table plus hand-written
// corner sequences, with a bus model and response scoreboard.
module tb_sccb_arbiter;

  localparam int TO = 100;

  logic        clk25 = 1'b0, RESET = 1'b1, init_done = 1'b0;
  logic [1:0]  r_rreq = '0, r_wreq = '0;
  logic [15:0] r_addr = '0, r_wdata = '0;
  logic [1:0]  r_done, r_err;
  logic [7:0]  r_rdata, m_addr, m_data_write;
  logic [7:0]  m_data_read = '0;
  logic        m_rreq, m_wreq, busy;
  logic        m_com_done = 1'b0;

  sccb_arbiter #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
    .clk25(clk25), .RESET(RESET), .init_done(init_done),
    .r_rreq(r_rreq), .r_wreq(r_wreq), .r_addr(r_addr), .r_wdata(r_wdata),
    .r_done(r_done), .r_err(r_err), .r_rdata(r_rdata),
    .m_rreq(m_rreq), .m_wreq(m_wreq), .m_addr(m_addr), .m_data_write(m_data_write),
    .m_data_read(m_data_read), .m_com_done(m_com_done), .busy(busy)
  );

  always #20 clk25 = ~clk25;

  typedef struct { int req; logic rd, wr; logic [7:0] addr, wdata, data; int delay; logic hang, err; } vec_t;
  typedef struct { int req; logic rd; logic [7:0] addr, wdata, data; int delay; logic hang; } bus_t;
  typedef struct { logic [1:0] done, err; logic [7:0] rdata; } resp_t;

  resp_t rq[$];
  bus_t  bq[$];
  bus_t  cur;
  vec_t  vecs[8];
  int    n_vec = 0, n_bad = 0;
  int    wcnt = 0, last_wcnt = 0;
  logic  stray = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: scoreboard responses, release finished requesters, model the bus.
  task automatic step();
    resp_t e;
    @(negedge clk25);
    if (r_done != '0 || r_err != '0) begin
      if (rq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done: done=%b err=%b", r_done, r_err);
      end else begin
        e = rq.pop_front();
        check("resp_done", 32'(r_done), 32'(e.done));
        check("resp_err", 32'(r_err), 32'(e.err));
        check("resp_rdata", 32'(r_rdata), 32'(e.rdata));
      end
      for (int i = 0; i < 2; i++)
        if (r_done[i]) begin r_rreq[i] = 1'b0; r_wreq[i] = 1'b0; end
    end
    if (m_rreq || m_wreq) begin
      wcnt++;
      if (wcnt == 1) begin
        if (bq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_bus: rreq=%b wreq=%b addr=%h", m_rreq, m_wreq, m_addr);
          cur = '{req: 0, rd: m_rreq, addr: m_addr, wdata: m_data_write, data: 8'h00, delay: 0, hang: 1'b1};
        end else cur = bq.pop_front();
        // Requester-side changes after the grant must not reach the bus.
        if (cur.req == 0) begin r_addr[7:0] = ~r_addr[7:0]; r_wdata[7:0] = ~r_wdata[7:0]; end
        else begin r_addr[15:8] = ~r_addr[15:8]; r_wdata[15:8] = ~r_wdata[15:8]; end
      end
      check("bus_rw", 32'({m_rreq, m_wreq}), cur.rd ? 32'd2 : 32'd1);
      check("bus_addr", 32'(m_addr), 32'(cur.addr));
      if (!cur.rd) check("bus_wdata", 32'(m_data_write), 32'(cur.wdata));
      m_com_done  = !cur.hang && (wcnt == cur.delay);
      m_data_read = m_com_done ? cur.data : ~cur.data;
    end else begin
      if (wcnt != 0) last_wcnt = wcnt;
      wcnt        = 0;
      m_com_done  = stray;
      stray       = 1'b0;
      m_data_read = 8'hEE;
    end
  endtask

  task automatic drain();
    int k = 0;
    do begin step(); k++; end
    while (k < 2000 && (rq.size() != 0 || bq.size() != 0 || busy || (r_rreq | r_wreq) != '0));
    if (k >= 2000) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: rq=%0d bq=%0d busy=%b", rq.size(), bq.size(), busy);
    end
  endtask

  task automatic drive(input int req, input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    if (req == 0) begin r_rreq[0] = rd; r_wreq[0] = wr; r_addr[7:0] = a; r_wdata[7:0] = d; end
    else begin r_rreq[1] = rd; r_wreq[1] = wr; r_addr[15:8] = a; r_wdata[15:8] = d; end
  endtask

  task automatic expect_txn(input vec_t v);
    logic [1:0] m;
    m = (v.req == 0) ? 2'b01 : 2'b10;
    if (!(v.rd && v.wr))
      bq.push_back('{req: v.req, rd: v.rd, addr: v.addr, wdata: v.wdata,
                     data: v.rd ? v.data : 8'hC3, delay: v.delay, hang: v.hang});
    rq.push_back('{done: m, err: v.err ? m : 2'b00, rdata: (v.rd && !v.err) ? v.data : 8'h00});
  endtask

  task automatic txn(input vec_t v);
    expect_txn(v);
    drive(v.req, v.rd, v.wr, v.addr, v.wdata);
  endtask

  initial begin
    vec_t v0, v1;
    logic saw_busy;
    int   k;
    //         req rd wr  addr   wdata  data   dly hang err
    vecs[0] = '{0, 1, 0, 8'h0A, 8'h00, 8'h76,  90, 0, 0};
    vecs[1] = '{1, 0, 1, 8'h12, 8'h80, 8'h00,   5, 0, 0};
    vecs[2] = '{1, 1, 0, 8'h33, 8'h00, 8'hA5, 100, 0, 0};  // com_done on the timeout cycle
    vecs[3] = '{0, 0, 1, 8'h40, 8'hD0, 8'h00,   1, 0, 0};
    vecs[4] = '{0, 0, 1, 8'h55, 8'h11, 8'h00,   0, 1, 1};  // write timeout
    vecs[5] = '{1, 1, 0, 8'h66, 8'h00, 8'h5C,   0, 1, 1};  // read timeout, rdata forced 0
    vecs[6] = '{1, 1, 1, 8'h77, 8'h22, 8'h00,   0, 0, 1};  // conflicting request
    vecs[7] = '{0, 1, 0, 8'h7F, 8'h00, 8'hFF,   2, 0, 0};

    repeat (3) @(negedge clk25);
    check("reset_outputs", 32'({r_done, r_err, r_rdata, m_rreq, m_wreq, m_addr, m_data_write, busy}), 32'd0);
    RESET = 1'b0;
    init_done = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      last_wcnt = 0;
      txn(vecs[i]);
      drain();
      if (vecs[i].hang) check("timeout_len", 32'(last_wcnt), 32'(TO));
      else if (!(vecs[i].rd && vecs[i].wr)) check("req_len", 32'(last_wcnt), 32'(vecs[i].delay));
      else check("conflict_no_bus", 32'(last_wcnt), 32'd0);
    end

    // Grants are blocked while init_done is low, then follow one cycle after it rises.
    init_done = 1'b0;
    txn('{1, 0, 1, 8'h20, 8'h01, 8'h00, 3, 0, 0});
    saw_busy = 1'b0;
    repeat (50) begin step(); saw_busy |= busy | m_rreq | m_wreq; end
    check("gate_idle", 32'(saw_busy), 32'd0);
    init_done = 1'b1;
    step();
    check("gate_grant", 32'(busy), 32'd1);
    drain();

    // Reset in WAIT drops the bus at once, with no completion.
    bq.push_back('{req: 0, rd: 1'b1, addr: 8'h21, wdata: 8'h00, data: 8'h00, delay: 0, hang: 1'b1});
    drive(0, 1, 0, 8'h21, 8'h00);
    k = 0;
    do begin step(); k++; end while (!m_rreq && k < 10);
    check("rst_reached_wait", 32'(m_rreq), 32'd1);
    repeat (5) step();
    RESET = 1'b1;
    #1;
    check("rst_drop", 32'({m_rreq, m_wreq, busy, r_done}), 32'd0);
    r_rreq = '0;
    r_wreq = '0;
    repeat (2) step();
    RESET = 1'b0;
    stray = 1'b1;
    repeat (3) step();
    check("stray_done_ignored", 32'({busy, r_done}), 32'd0);
    txn('{1, 1, 0, 8'h30, 8'h00, 8'h9C, 4, 0, 0});
    drain();

    // Simultaneous writes: last grant was requester 1, so requester 0 goes first.
    v0 = '{0, 0, 1, 8'h12, 8'h80, 8'h00, 3, 0, 0};
    v1 = '{1, 0, 1, 8'h40, 8'hD0, 8'h00, 3, 0, 0};
    expect_txn(v0); expect_txn(v1);
    drive(0, 0, 1, 8'h12, 8'h80); drive(1, 0, 1, 8'h40, 8'hD0);
    drain();

    // After a lone requester-0 turn, a tie goes to requester 1.
    txn('{0, 0, 1, 8'h01, 8'h02, 8'h00, 2, 0, 0});
    drain();
    expect_txn(v1); expect_txn(v0);
    drive(0, 0, 1, 8'h12, 8'h80); drive(1, 0, 1, 8'h40, 8'hD0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
